// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding, load-use,
// redirect flushes and multi-cycle Execute sequencing. Optional macro: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_Rs1D,
  input  logic [4:0]       i_Rs2D,
  input  logic [4:0]       i_Rs1E,
  input  logic [4:0]       i_Rs2E,
  input  logic [4:0]       i_RdE,
  input  logic [4:0]       i_RdM,
  input  logic [4:0]       i_RdW,
  input  logic             i_RegWriteM,
  input  logic             i_RegWriteW,
  input  logic             i_LoadE,
  input  logic [1:0]       i_PCSrcE,
  input  logic             i_MultiCycE,
  output logic [1:0]       o_ForwardAE,
  output logic [1:0]       o_ForwardBE,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_StallE,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_McStart,
  output logic             o_McBusy,
  output logic [CNT_W-1:0] o_StallCnt,
  output logic [CNT_W-1:0] o_FlushCnt,
  output logic [1:0]       o_McState
);

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

  localparam logic [3:0] MC_LAT_M1 = 4'(MC_LAT - 1);

  mc_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mc_start;
  logic       mc_stall;
  logic       lw_stall;
  logic       redirect;

  // M-stage producer is younger than W, so its value wins on a double match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    o_ForwardAE = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
    o_ForwardBE = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
  end

  always_comb begin
    lw_stall = i_LoadE && (i_RdE != 5'd0) && ((i_Rs1D == i_RdE) || (i_Rs2D == i_RdE));
    redirect = (i_PCSrcE != 2'b00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      state <= MC_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DONE is the cycle the op leaves E, so a still-high i_MultiCycE is not a new op.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_start  = 1'b0;
    mc_stall  = 1'b0;
    case (state)
      MC_IDLE: begin
        if (i_MultiCycE) begin
          mc_start = 1'b1;
          mc_stall = 1'b1;
          cnt_nxt  = MC_LAT_M1;
          state_nxt = (MC_LAT == 1) ? MC_DONE : MC_BUSY;
        end
      end
      MC_BUSY: begin
        mc_stall = 1'b1;
        cnt_nxt  = cnt - 4'd1;
        if (cnt == 4'd1)
          state_nxt = MC_DONE;
      end
      MC_DONE: begin
        state_nxt = MC_IDLE;
      end
      default: begin
        state_nxt = MC_IDLE;
      end
    endcase
  end

  // Reset masks every pipeline-control output; forwarding stays live.
  always_comb begin
    o_StallF  = !i_rstn && (lw_stall || mc_stall);
    o_StallD  = !i_rstn && (lw_stall || mc_stall);
    o_StallE  = !i_rstn && mc_stall;
    o_FlushD  = !i_rstn && redirect;
    o_FlushE  = !i_rstn && (lw_stall || redirect) && !mc_stall;
    o_McStart = !i_rstn && mc_start;
    o_McBusy  = (state == MC_BUSY);
    o_McState = state;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (o_StallF && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (o_FlushD && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign o_StallCnt = stall_cnt;
  assign o_FlushCnt = flush_cnt;
`else
  assign o_StallCnt = '0;
  assign o_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle hazard vectors plus
// hand-written multi-cycle sequences (MC_LAT=4) with a perf-counter model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic             regwm, regww, loade, multicyc;
  logic [1:0]       pcsrc;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, mc_start, mc_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       mc_state;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       se;
    logic       fd;
    logic       fe;
    logic       st;
    logic       busy;
    logic [1:0] state;
  } exp_t;

  typedef struct {
    string      nm;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, loade;
    logic [1:0] pcsrc;
    exp_t       e;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  vec_t vq[$];

  pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rst),
    .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e), .i_Rs2E(rs2e),
    .i_RdE(rde), .i_RdM(rdm), .i_RdW(rdw),
    .i_RegWriteM(regwm), .i_RegWriteW(regww), .i_LoadE(loade),
    .i_PCSrcE(pcsrc), .i_MultiCycE(multicyc),
    .o_ForwardAE(fwd_a), .o_ForwardBE(fwd_b),
    .o_StallF(stall_f), .o_StallD(stall_d), .o_StallE(stall_e),
    .o_FlushD(flush_d), .o_FlushE(flush_e),
    .o_McStart(mc_start), .o_McBusy(mc_busy),
    .o_StallCnt(stall_cnt), .o_FlushCnt(flush_cnt), .o_McState(mc_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [1:0] fa, logic [1:0] fb, logic sf, logic se, logic fd,
                              logic fe, logic st, logic busy, logic [1:0] state);
    exp_t e;
    e.fa = fa; e.fb = fb; e.sf = sf; e.se = se; e.fd = fd;
    e.fe = fe; e.st = st; e.busy = busy; e.state = state;
    return e;
  endfunction

  task automatic add_vec(input string nm, input logic [4:0] v_rs1d, input logic [4:0] v_rs2d,
                         input logic [4:0] v_rs1e, input logic [4:0] v_rs2e,
                         input logic [4:0] v_rde, input logic [4:0] v_rdm,
                         input logic [4:0] v_rdw, input logic v_wm, input logic v_ww,
                         input logic v_ld, input logic [1:0] v_pc, input exp_t e);
    vec_t v;
    v.nm = nm; v.rs1d = v_rs1d; v.rs2d = v_rs2d; v.rs1e = v_rs1e; v.rs2e = v_rs2e;
    v.rde = v_rde; v.rdm = v_rdm; v.rdw = v_rdw; v.regwm = v_wm; v.regww = v_ww;
    v.loade = v_ld; v.pcsrc = v_pc; v.e = e;
    vq.push_back(v);
  endtask

  task automatic clear_inputs();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    regwm = 0; regww = 0; loade = 0; pcsrc = 0; multicyc = 0;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs are already driven; sample at negedge, then advance one cycle and
  // update the counter model with what this cycle should have contributed.
  task automatic check_cycle(input string nm, input exp_t e);
    @(negedge clk);
    chk({nm, ".fwd_a"},     32'(fwd_a),    32'(e.fa));
    chk({nm, ".fwd_b"},     32'(fwd_b),    32'(e.fb));
    chk({nm, ".stall_f"},   32'(stall_f),  32'(e.sf));
    chk({nm, ".stall_d"},   32'(stall_d),  32'(e.sf));
    chk({nm, ".stall_e"},   32'(stall_e),  32'(e.se));
    chk({nm, ".flush_d"},   32'(flush_d),  32'(e.fd));
    chk({nm, ".flush_e"},   32'(flush_e),  32'(e.fe));
    chk({nm, ".mc_start"},  32'(mc_start), 32'(e.st));
    chk({nm, ".mc_busy"},   32'(mc_busy),  32'(e.busy));
    chk({nm, ".mc_state"},  32'(mc_state), 32'(e.state));
    chk({nm, ".stall_cnt"}, stall_cnt,     m_stall);
    chk({nm, ".flush_cnt"}, flush_cnt,     m_flush);
    @(posedge clk);
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end else if (PERF) begin
      if (e.sf && m_stall != '1) m_stall = m_stall + 1;
      if (e.fd && m_flush != '1) m_flush = m_flush + 1;
    end
    #1;
  endtask

  task automatic mc_op(input string nm);
    multicyc = 1;
    check_cycle({nm, ".c0"}, mk(0, 0, 1, 1, 0, 0, 1, 0, S_IDLE));
    for (int i = 1; i <= 3; i++)
      check_cycle($sformatf("%s.c%0d", nm, i), mk(0, 0, 1, 1, 0, 0, 0, 1, S_BUSY));
    check_cycle({nm, ".c4"}, mk(0, 0, 0, 0, 0, 0, 0, 0, S_DONE));
    multicyc = 0;
    check_cycle({nm, ".c5"}, mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
  endtask

  initial begin
    // name                rs1d rs2d rs1e rs2e rde rdm rdw wm ww ld pc
    add_vec("fwd_m_prio",   0,  0,  5,  0,  0,  5,  5, 1, 1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("fwd_w",        0,  0,  5,  0,  0,  5,  5, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("fwd_zero",     0,  0,  0,  0,  0,  0,  0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("fwd_b_m_a_w",  0,  0,  3,  9,  0,  9,  3, 1, 1, 0, 0, mk(1, 2, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("fwd_b_prio",   0,  0,  0,  4,  0,  4,  4, 1, 1, 0, 0, mk(0, 2, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("fwd_nowrite",  0,  0,  6,  6,  0,  6,  6, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("lu_rs2",       0,  7,  0,  0,  7,  0,  0, 0, 0, 1, 0, mk(0, 0, 1, 0, 0, 1, 0, 0, S_IDLE));
    add_vec("lu_rs1",      12,  0,  0,  0, 12,  0,  0, 0, 0, 1, 0, mk(0, 0, 1, 0, 0, 1, 0, 0, S_IDLE));
    add_vec("lu_rd0",       0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("lu_nomatch",   6,  8,  0,  0,  7,  0,  0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("lu_notload",   0,  7,  0,  0,  7,  0,  0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    add_vec("br_01",        0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 1, 0, 0, S_IDLE));
    add_vec("br_10",        0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 2, mk(0, 0, 0, 0, 1, 1, 0, 0, S_IDLE));
    add_vec("br_lu",        0,  7,  0,  0,  7,  0,  0, 0, 0, 1, 1, mk(0, 0, 1, 0, 1, 1, 0, 0, S_IDLE));

    // Reset masks control outputs even with every hazard present; forwarding stays live.
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    loade = 1; rde = 7; rs2d = 7; pcsrc = 1; multicyc = 1;
    rdm = 5; regwm = 1; rs1e = 5;
    check_cycle("reset_mask", mk(2, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    clear_inputs();
    rst = 0;
    check_cycle("post_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));

    foreach (vq[i]) begin
      rs1d = vq[i].rs1d; rs2d = vq[i].rs2d; rs1e = vq[i].rs1e; rs2e = vq[i].rs2e;
      rde = vq[i].rde; rdm = vq[i].rdm; rdw = vq[i].rdw;
      regwm = vq[i].regwm; regww = vq[i].regww; loade = vq[i].loade;
      pcsrc = vq[i].pcsrc; multicyc = 0;
      check_cycle(vq[i].nm, vq[i].e);
    end
    clear_inputs();

    mc_op("mc_basic");

    // Load-use alongside the multi-cycle op: E held, never bubbled.
    loade = 1; rde = 3; rs1d = 3; multicyc = 1;
    check_cycle("mc_lu.c0", mk(0, 0, 1, 1, 0, 0, 1, 0, S_IDLE));
    for (int i = 1; i <= 3; i++)
      check_cycle($sformatf("mc_lu.c%0d", i), mk(0, 0, 1, 1, 0, 0, 0, 1, S_BUSY));
    loade = 0;
    check_cycle("mc_lu.c4", mk(0, 0, 0, 0, 0, 0, 0, 0, S_DONE));
    clear_inputs();
    check_cycle("mc_lu.c5", mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Redirect coinciding with a multi-cycle start: FlushD still asserts, no bubble.
    multicyc = 1; pcsrc = 1;
    check_cycle("mc_br.c0", mk(0, 0, 1, 1, 1, 0, 1, 0, S_IDLE));
    pcsrc = 0;
    for (int i = 1; i <= 3; i++)
      check_cycle($sformatf("mc_br.c%0d", i), mk(0, 0, 1, 1, 0, 0, 0, 1, S_BUSY));
    check_cycle("mc_br.c4", mk(0, 0, 0, 0, 0, 0, 0, 0, S_DONE));
    multicyc = 0;
    check_cycle("mc_br.c5", mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Reset in the second BUSY cycle aborts the op.
    multicyc = 1;
    check_cycle("mc_rst.c0", mk(0, 0, 1, 1, 0, 0, 1, 0, S_IDLE));
    check_cycle("mc_rst.c1", mk(0, 0, 1, 1, 0, 0, 0, 1, S_BUSY));
    rst = 1;
    check_cycle("mc_rst.c2", mk(0, 0, 0, 0, 0, 0, 0, 1, S_BUSY));
    rst = 0; multicyc = 0;
    check_cycle("mc_rst.c3", mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
    mc_op("mc_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates the Execute-stage forwarding selects.
- Detects load-use hazards.
- Stalls and flushes the F/D/E pipeline registers on taken branches and jumps.
- Sequences a fixed-latency multi-cycle Execute operation (iterative mul/div slot) through a small FSM that holds the instruction in E until its result is ready.
- Sits beside the Execute datapath and drives the pipeline-register enables and clears.

Parameters:
- MC_LAT, 4, cycles a multi-cycle op needs in E before its result is valid; legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; synchronous, active-high (1 = reset)
- i_Rs1D  in  5  rs1 of instruction in Decode
- i_Rs2D  in  5  rs2 of instruction in Decode
- i_Rs1E  in  5  rs1 of instruction in Execute
- i_Rs2E  in  5  rs2 of instruction in Execute
- i_RdE  in  5  rd of instruction in Execute
- i_RdM  in  5  rd of instruction in Memory
- i_RdW  in  5  rd of instruction in Writeback
- i_RegWriteM  in  1  Memory-stage instruction writes rd
- i_RegWriteW  in  1  Writeback-stage instruction writes rd
- i_LoadE  in  1  Execute-stage instruction is a load
- i_PCSrcE  in  2  PC select from Execute; 00 = sequential, 01/10 = redirect
- i_MultiCycE  in  1  Execute-stage instruction is a multi-cycle op
- o_ForwardAE  out  2  SrcA mux select
- o_ForwardBE  out  2  SrcB/write-data mux select
- o_StallF  out  1  hold PC
- o_StallD  out  1  hold IF/ID register
- o_StallE  out  1  hold ID/EX register
- o_FlushD  out  1  clear IF/ID register
- o_FlushE  out  1  clear ID/EX register (insert bubble)
- o_McStart  out  1  one-cycle start pulse to the multi-cycle unit
- o_McBusy  out  1  FSM is in BUSY
- o_StallCnt  out  CNT_W  cycles with o_StallF=1
- o_FlushCnt  out  CNT_W  cycles with o_FlushD=1

Behaviour:
Forwarding (combinational, shown for A; B is identical using i_Rs2E):
- 2'b10 (M-stage value) if i_RegWriteM & i_RdM!=0 & i_RdM==i_Rs1E.
- Else 2'b01 (ResultW) if i_RegWriteW & i_RdW!=0 & i_RdW==i_Rs1E.
- Else 2'b00 (register file).
- M-stage match has priority over W-stage match.

Load-use:
- lwStall = i_LoadE & i_RdE!=0 & (i_Rs1D==i_RdE | i_Rs2D==i_RdE).

FSM states: IDLE, BUSY, DONE. Registered state plus a 4-bit down-counter.
- IDLE: on i_MultiCycE=1, assert o_McStart combinationally, load counter = MC_LAT-1, go to BUSY. If MC_LAT==1, go directly to DONE.
- BUSY: decrement the counter each cycle; when counter==1, go to DONE on that edge.
- DONE: ignore i_MultiCycE (the same instruction is still in E); go to IDLE. The instruction leaves E on this edge.
- mcStall = (IDLE & i_MultiCycE) | BUSY.
- Result: exactly MC_LAT stall cycles and MC_LAT+1 cycles of E residence per multi-cycle op.

Outputs:
- o_StallF = o_StallD = lwStall | mcStall.
- o_StallE = mcStall.
- o_FlushD = (i_PCSrcE!=0).
- o_FlushE = (lwStall | i_PCSrcE!=0) & !mcStall. A multi-cycle op is never bubbled.
- o_McBusy = (state==BUSY).

Simultaneous events:
- lwStall and mcStall together: E is held, no bubble is inserted, F/D are held.
- A redirect cannot coincide with a multi-cycle op in E. If it does, FlushD still asserts.

Reset:
- While i_rstn=1, all stall, flush and o_McStart outputs are forced to 0.
- On the next edge: state=IDLE, counter=0, both perf counters=0.
- Reset asserted mid-BUSY aborts the op and returns to IDLE.
- Forwarding outputs are not gated by reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: o_StallCnt and o_FlushCnt increment by 1 on each qualifying cycle and saturate at all-ones (no wrap).
- Undefined: the counter logic is omitted and both ports are tied to 0.

Test Plan:
- Forwarding: i_RdM=5, i_RegWriteM=1, i_RdW=5, i_RegWriteW=1, i_Rs1E=5 -> o_ForwardAE=10. With i_RegWriteM=0 -> 01. With i_Rs1E=0 and all rd=0 -> 00.
- Load-use: i_LoadE=1, i_RdE=7, i_Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle, StallE=0. With i_RdE=0 -> no stall.
- Branch taken: i_PCSrcE=01 for 1 cycle -> FlushD=FlushE=1 that cycle, stalls 0. o_FlushCnt increments by 1 (macro on).
- Multi-cycle, MC_LAT=4: i_MultiCycE held high -> o_McStart=1 cycle 0 only; StallF/D/E=1 cycles 0-3, 0 in cycle 4. o_McBusy=1 cycles 1-3. o_StallCnt += 4.
- Multi-cycle plus load-use together: i_LoadE=1, i_RdE=3, i_Rs1D=3, i_MultiCycE=1 -> FlushE=0 throughout, StallE=1 for 4 cycles.
- Reset mid-op: assert i_rstn in the 2nd BUSY cycle -> next cycle state=IDLE, all stalls 0, counters 0. A new i_MultiCycE after release gives the full 4-cycle stall again.
